pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch sequencer. It consumes the branch decision (target address plus take-branch strobe) produced by the condition arbiter. It holds the 8-bit PC, fetches instruction bytes from instruction memory over a req/ack handshake, and delivers each byte to decode over a valid/ready handshake. It sits between the arbiter and decode, closing the branch loop.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit.sv | 99 +++++++++
 tb/tb_pc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and fetch-sequencer state encoding.
// Imported by the fetch unit, condition arbiter and register file.
package pc_fetch_unit_pkg;

    localparam int          CPU_ADDR_W   = 8;
    localparam int          CPU_DATA_W   = 8;
    localparam logic [7:0]  CPU_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DELIVER = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_e;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches one byte per instruction over
// imem req/ack, hands it to decode over valid/ready, and applies branch/halt decisions.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              branch_taken,
    input  logic              stall,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            ST_FETCH: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (branch_taken) begin
                    // A same-cycle ack is dropped; the next request goes to the target.
                    pc_d = branch_target;
                end else if (!stall && imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 1'b1;
                    state_d    = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        imem_addr   = pc_q;
        instr_out   = instr_q;
        instr_pc    = instr_pc_q;
        case (state_q)
            // NOTE: rst_n gates the request so it stays low for the whole reset window.
            ST_FETCH:   imem_req    = rst_n && !stall;
            ST_DELIVER: instr_valid = 1'b1;
            default:    ;
        endcase
    end

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_pc_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       branch_taken = 1'b0;
    logic       stall = 1'b0;
    logic       halt = 1'b0;
    logic       imem_ack = 1'b0;
    logic       instr_ready = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;

    logic       w_req;
    logic [7:0] w_addr;
    logic [7:0] w_rdata;
    logic [7:0] w_out;
    logic [7:0] w_ipc;
    logic       w_valid;

    always #5 clk = ~clk;

    // Instruction memory content: every byte is its address XOR 0xA5.
    assign imem_rdata = imem_addr ^ 8'hA5;
    assign w_rdata    = w_addr ^ 8'hA5;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_target (branch_target),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    // Second instance starting near the top of the address space, free-running.
    pc_fetch_unit #(.RESET_PC(8'hFE)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_target (8'h00),
        .branch_taken  (1'b0),
        .stall         (1'b0),
        .halt          (1'b0),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (1'b1),
        .imem_rdata    (w_rdata),
        .instr_out     (w_out),
        .instr_pc      (w_ipc),
        .instr_valid   (w_valid),
        .instr_ready   (1'b1)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Transaction-level model: PC, an optional pending instruction, and a halted flag.
    logic [7:0] m_pc;
    logic [7:0] m_out;
    logic [7:0] m_ipc;
    bit         m_has;
    bit         m_halted;

    // Outputs sampled mid-cycle by the most recent tick.
    logic       s_req, s_valid, sw_req, sw_valid;
    logic [7:0] s_addr, s_out, s_ipc, sw_addr, sw_ipc;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 8'h00;
        m_out    = 8'h00;
        m_ipc    = 8'h00;
        m_has    = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the model,
    // then advance the model at the rising edge with the same inputs.
    task automatic tick(input bit br, input logic [7:0] tgt, input bit st, input bit hl,
                        input bit ak, input bit rd);
        @(negedge clk);
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        halt          = hl;
        imem_ack      = ak;
        instr_ready   = rd;
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = instr_valid;
        s_out    = instr_out;
        s_ipc    = instr_pc;
        sw_req   = w_req;
        sw_addr  = w_addr;
        sw_valid = w_valid;
        sw_ipc   = w_ipc;
        check("model_req", {7'b0, s_req}, {7'b0, !m_halted && !m_has && !st});
        check("model_addr", s_addr, m_pc);
        check("model_valid", {7'b0, s_valid}, {7'b0, m_has});
        if (m_has) begin
            check("model_instr_out", s_out, m_out);
            check("model_instr_pc", s_ipc, m_ipc);
        end
        @(posedge clk);
        if (!m_halted) begin
            if (hl) begin
                m_halted = 1'b1;
                m_has    = 1'b0;
            end else if (m_has) begin
                if (br) begin
                    m_pc  = tgt;
                    m_has = 1'b0;
                end else if (rd) begin
                    m_has = 1'b0;
                end
            end else if (br) begin
                m_pc = tgt;
            end else if (!st && ak) begin
                m_out = m_pc ^ 8'hA5;
                m_ipc = m_pc;
                m_pc  = m_pc + 8'd1;
                m_has = 1'b1;
            end
        end
    endtask

    // Asynchronous reset pulse taken mid-cycle, checking outputs while still in reset.
    task automatic do_reset();
        @(negedge clk);
        branch_taken = 1'b0;
        stall        = 1'b0;
        halt         = 1'b0;
        imem_ack     = 1'b0;
        instr_ready  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", {7'b0, imem_req}, 8'h00);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_valid", {7'b0, instr_valid}, 8'h00);
        check("rst_instr_out", instr_out, 8'h00);
        check("rst_instr_pc", instr_pc, 8'h00);
        check("rst_wrap_addr", w_addr, 8'hFE);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("wrap_first_req", {7'b0, w_req}, 8'h01);
        check("wrap_first_addr", w_addr, 8'hFE);
    endtask

    initial begin
        logic [7:0] wrap_ipc_exp [3];
        logic [7:0] wrap_addr_exp [2];
        model_reset();
        wrap_ipc_exp  = '{8'hFE, 8'hFF, 8'h00};
        wrap_addr_exp = '{8'hFF, 8'h00};

        // Free-run: ack every request, decode always ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i % 2 == 0) begin
                check("fr_req", {7'b0, s_req}, 8'h01);
                check("fr_addr", s_addr, 8'(i / 2));
                check("fr_valid_lo", {7'b0, s_valid}, 8'h00);
                check("wrap_valid", {7'b0, sw_valid}, 8'h01);
                check("wrap_instr_pc", sw_ipc, wrap_ipc_exp[i / 2]);
            end else begin
                check("fr_valid_hi", {7'b0, s_valid}, 8'h01);
                check("fr_instr_pc", s_ipc, 8'(i / 2));
                check("fr_instr_out", s_out, 8'(i / 2) ^ 8'hA5);
                if (i < 5) check("wrap_addr", sw_addr, wrap_addr_exp[i / 2]);
            end
        end

        // Branch in DELIVER without ready flushes the pending instruction.
        do_reset();
        tick(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bd_fetch_addr", s_addr, 8'h05);
        tick(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bd_valid_before", {7'b0, s_valid}, 8'h01);
        check("bd_instr_pc", s_ipc, 8'h05);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bd_valid_flushed", {7'b0, s_valid}, 8'h00);
        check("bd_next_addr", s_addr, 8'h40);
        check("bd_next_req", {7'b0, s_req}, 8'h01);

        // Branch coincident with ack in FETCH discards the fetched byte.
        do_reset();
        tick(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ba_addr", s_addr, 8'h10);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ba_no_valid", {7'b0, s_valid}, 8'h00);
        check("ba_target_addr", s_addr, 8'h80);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ba_valid", {7'b0, s_valid}, 8'h01);
        check("ba_instr_pc", s_ipc, 8'h80);
        check("ba_instr_out", s_out, 8'h25);

        // Stall with ack held high: no request, PC frozen, then resume at same address.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
            check("st_req", {7'b0, s_req}, 8'h00);
            check("st_addr", s_addr, 8'h00);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("st_resume_req", {7'b0, s_req}, 8'h01);
        check("st_resume_addr", s_addr, 8'h00);

        // Halt while an instruction is pending; branches are ignored afterwards.
        do_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("h_valid_before", {7'b0, s_valid}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1);
            check("h_valid", {7'b0, s_valid}, 8'h00);
            check("h_req", {7'b0, s_req}, 8'h00);
            check("h_addr", s_addr, 8'h01);
        end
        do_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("h_reset_addr", s_addr, 8'h00);
        check("h_reset_req", {7'b0, s_req}, 8'h01);

        // Reset asserted while an instruction is pending.
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mr_pending", {7'b0, s_valid}, 8'h01);
        do_reset();

        // Randomized traffic with periodic resets landing in arbitrary states.
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 399) do_reset();
            tick(($urandom_range(0, 7) == 0),
                 8'($urandom),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 149) == 0),
                 1'($urandom),
                 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_fetch_unit
